// File: rtl/pc_next_unit.sv
// Program-counter register and next-PC sequencer for the fetch path; optional delay slot under BRANCH_DELAY_SLOT_EN.
// Latency: redirect target on pc 1 cycle later (2 cycles with the delay slot); pc_plus4 is combinational.
// Backpressure: stall freezes pc, state and latched target and ignores redirects; FAULT is sticky until rst.
module pc_next_unit #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_offset,
    input  logic             jmp,
    input  logic [25:0]      jmp_index,
    input  logic             jr,
    input  logic [WIDTH-1:0] jr_target,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             in_slot,
    output logic             fault
);

    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

`ifdef BRANCH_DELAY_SLOT_EN
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SLOT  = 2'd1,
        FAULT = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FAULT = 2'd2
    } state_t;
`endif

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] pc_d;

    logic             redir_vld;
    logic [WIDTH-1:0] redir_tgt;
    logic             redir_misaligned;
    logic [WIDTH-1:0] br_tgt;
    logic [WIDTH-1:0] jmp_tgt;

`ifdef BRANCH_DELAY_SLOT_EN
    logic [WIDTH-1:0] lat_q;
    logic [WIDTH-1:0] lat_d;
`endif

    assign pc_plus4 = pc + PC_STEP;
    assign br_tgt   = pc_plus4 + br_offset;
    assign jmp_tgt  = {pc_plus4[WIDTH-1:28], jmp_index, 2'b00};

    // Priority jr > jmp > branch; only the winner's alignment matters.
    always_comb begin
        redir_vld = jr | jmp | br_taken;
        redir_tgt = br_tgt;
        if (jr) begin
            redir_tgt = jr_target;
        end else if (jmp) begin
            redir_tgt = jmp_tgt;
        end
        redir_misaligned = redir_vld & (|redir_tgt[1:0]);
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc;
`ifdef BRANCH_DELAY_SLOT_EN
        lat_d   = lat_q;
`endif
        case (state_q)
            RUN: begin
                if (!stall) begin
                    if (redir_misaligned) begin
                        state_d = FAULT;
                    end else if (redir_vld) begin
`ifdef BRANCH_DELAY_SLOT_EN
                        pc_d    = pc_plus4;
                        lat_d   = redir_tgt;
                        state_d = SLOT;
`else
                        pc_d    = redir_tgt;
`endif
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end
`ifdef BRANCH_DELAY_SLOT_EN
            // Redirects seen during the slot are architecturally undefined and dropped.
            SLOT: begin
                if (!stall) begin
                    pc_d    = lat_q;
                    state_d = RUN;
                end
            end
`endif
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = FAULT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            pc      <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc      <= pc_d;
        end
    end

`ifdef BRANCH_DELAY_SLOT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_q <= '0;
        end else begin
            lat_q <= lat_d;
        end
    end

    assign in_slot = (state_q == SLOT);
`else
    assign in_slot = 1'b0;
`endif

    assign fault = (state_q == FAULT);

endmodule

// File: tb/tb_pc_next_unit.sv
// Bench for pc_next_unit: directed scenarios then random traffic against a behavioural PC model.
module tb_pc_next_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_offset = '0;
    logic        jmp = 1'b0;
    logic [25:0] jmp_index = '0;
    logic        jr = 1'b0;
    logic [31:0] jr_target = '0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        in_slot;
    logic        fault;

    int compared = 0;
    int mismatched = 0;

    // Behavioural model state
    logic [31:0] m_pc;
    logic        m_fault;
    logic        m_slot;
    logic [31:0] m_lat;

`ifdef BRANCH_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    pc_next_unit dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .br_taken  (br_taken),
        .br_offset (br_offset),
        .jmp       (jmp),
        .jmp_index (jmp_index),
        .jr        (jr),
        .jr_target (jr_target),
        .pc        (pc),
        .pc_plus4  (pc_plus4),
        .in_slot   (in_slot),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".pc_plus4"}, pc_plus4, m_pc + 32'd4);
        chk({tag, ".fault"}, {31'd0, fault}, {31'd0, m_fault});
        chk({tag, ".in_slot"}, {31'd0, in_slot}, {31'd0, m_slot});
    endtask

    // Model advance for one rising edge, using the inputs currently driven.
    task automatic model_edge();
        logic [31:0] nxt;
        logic [31:0] t;
        logic        any;
        if (stall || m_fault) return;
        if (m_slot) begin
            m_pc   = m_lat;
            m_slot = 1'b0;
            return;
        end
        nxt = m_pc + 32'd4;
        any = jr || jmp || br_taken;
        if (jr)            t = jr_target;
        else if (jmp)      t = (nxt & 32'hF000_0000) + ({6'd0, jmp_index} * 32'd4);
        else               t = nxt + br_offset;
        if (!any) begin
            m_pc = nxt;
        end else if (t % 4 != 0) begin
            m_fault = 1'b1;
        end else if (DS) begin
            m_pc   = nxt;
            m_lat  = t;
            m_slot = 1'b1;
        end else begin
            m_pc = t;
        end
    endtask

    task automatic drive(input logic s, input logic b, input logic [31:0] off,
                         input logic j, input logic [25:0] idx,
                         input logic r, input logic [31:0] tgt);
        stall = s; br_taken = b; br_offset = off;
        jmp = j; jmp_index = idx; jr = r; jr_target = tgt;
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        m_pc = 32'h0; m_fault = 1'b0; m_slot = 1'b0; m_lat = 32'h0;
        #1;
        chk_all(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        m_pc = 32'h0; m_fault = 1'b0; m_slot = 1'b0; m_lat = 32'h0;

        // Reset then four free-running cycles
        do_reset("reset");
        chk("reset.pc_lit", pc, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            cyc("free");
            chk("free.pc_lit", pc, 32'(i * 4));
        end

        // Backward branch at 0x10
        drive(0, 1, 32'hFFFF_FFF8, 0, 0, 0, 0);
        cyc("br_back");
`ifndef BRANCH_DELAY_SLOT_EN
        chk("br_back.lit", pc, 32'h0000_000C);
`endif
        drive(0, 0, 0, 0, 0, 0, 0);
        if (m_slot) cyc("br_back.slot");

        // Jump beats a simultaneous branch
        drive(0, 0, 0, 0, 0, 1, 32'h2000_0004);
        cyc("jr_setup");
        drive(0, 0, 0, 0, 0, 0, 0);
        if (m_slot) cyc("jr_setup.slot");
        drive(0, 1, 32'h0000_0100, 1, 26'h40, 0, 0);
        cyc("jmp_prio");
        drive(0, 0, 0, 0, 0, 0, 0);
        if (m_slot) cyc("jmp_prio.slot");
`ifndef BRANCH_DELAY_SLOT_EN
        chk("jmp_prio.lit", pc, 32'h2000_0100);
`endif

        // Misaligned jr -> sticky fault
        drive(0, 0, 0, 0, 0, 1, 32'h40);
        cyc("jr40");
        drive(0, 0, 0, 0, 0, 0, 0);
        if (m_slot) cyc("jr40.slot");
        drive(0, 0, 0, 0, 0, 1, 32'h1002);
        cyc("misalign");
        chk("misalign.fault_lit", {31'd0, fault}, 32'd1);
        drive(0, 1, 32'h40, 1, 26'h3, 0, 0);
        for (int i = 0; i < 6; i++) cyc("fault_hold");
        chk("fault_hold.pc_lit", pc, 32'h40);
        drive(0, 0, 0, 0, 0, 0, 0);
        do_reset("fault_rst");
        chk("fault_rst.fault_lit", {31'd0, fault}, 32'd0);

        // Stall with branch asserted is ignored
        drive(0, 0, 0, 0, 0, 1, 32'h20);
        cyc("jr20");
        drive(0, 0, 0, 0, 0, 0, 0);
        if (m_slot) cyc("jr20.slot");
        drive(1, 1, 32'h100, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc("stall");
        chk("stall.pc_lit", pc, 32'h20);
        drive(0, 0, 0, 0, 0, 0, 0);
        cyc("unstall");
        chk("unstall.pc_lit", pc, 32'h24);

`ifdef BRANCH_DELAY_SLOT_EN
        // Delay slot: branch at 0x10, jmp during slot ignored
        do_reset("ds_reset");
        for (int i = 0; i < 4; i++) cyc("ds_free");
        drive(0, 1, 32'h20, 0, 0, 0, 0);
        cyc("ds_br");
        chk("ds_br.pc_lit", pc, 32'h14);
        chk("ds_br.slot_lit", {31'd0, in_slot}, 32'd1);
        drive(0, 0, 0, 1, 26'h3FF, 0, 0);
        cyc("ds_tgt");
        chk("ds_tgt.pc_lit", pc, 32'h34);
        chk("ds_tgt.slot_lit", {31'd0, in_slot}, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0);
`endif

        // Random traffic, with occasional resets (including mid-slot / mid-fault)
        do_reset("rnd_reset");
        for (int n = 0; n < 600; n++) begin
            logic [31:0] off;
            logic [31:0] tgt;
            off = {$urandom_range(0, 255) == 0 ? $urandom : ($urandom & 32'hFFFF_FFFC)};
            if ($urandom_range(0, 15) == 0) off = off | 32'h1;
            tgt = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 19) == 0) tgt = tgt | 32'(($urandom_range(1, 3)));
            drive($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, off,
                  $urandom_range(0, 7) == 0, 26'($urandom),
                  $urandom_range(0, 9) == 0, tgt);
            if ($urandom_range(0, 39) == 0) begin
                do_reset("rnd_rst");
            end else begin
                cyc("rnd");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
